// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the branch target predictor.
// Optional feature macro: BTP_GSHARE_EN (global-history XOR on the PHT index).
package branch_target_predictor_pkg;

  localparam int BTP_DEFAULT_ENTRIES = 64;
  // Widest tag / PHT index the shared structs can carry; narrower configs zero-extend.
  localparam int BTP_MAX_TAG_BITS    = 30;
  localparam int BTP_MAX_IDX_BITS    = 16;

  typedef struct packed {
    logic                        valid;
    logic [BTP_MAX_TAG_BITS-1:0] tag;
    logic [31:0]                 target;
    logic                        is_jump;
  } btb_entry_type;

  typedef struct packed {
    logic                        valid;
    logic [31:0]                 pc;
    logic [BTP_MAX_IDX_BITS-1:0] pht_index;
    logic                        is_branch;
    logic                        is_jump;
    logic                        taken;
    logic                        correct_address;
    logic [31:0]                 target;
  } btp_update_type;

  typedef enum logic [1:0] {
    PHT_HOLD,
    PHT_INC,
    PHT_DEC,
    PHT_SET_WEAK_TAKEN
  } pht_op_e;

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and MEM-side resolution signals of the branch target predictor.
// master = pipeline side, slave = predictor side.
interface branch_target_predictor_if
  import branch_target_predictor_pkg::*;
#(
  parameter int IDX_BITS = $clog2(BTP_DEFAULT_ENTRIES)
);
  logic [31:0]         if_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [IDX_BITS-1:0] pred_pht_index;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic [IDX_BITS-1:0] upd_pht_index;
  logic                upd_is_branch;
  logic                upd_is_jump;
  logic                upd_taken;
  logic                upd_correct_address;
  logic [31:0]         upd_target;
  logic                flush;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_pht_index, upd_is_branch, upd_is_jump,
           upd_taken, upd_correct_address, upd_target, flush,
    input  pred_taken, pred_target, pred_pht_index
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_pht_index, upd_is_branch, upd_is_jump,
           upd_taken, upd_correct_address, upd_target, flush,
    output pred_taken, pred_target, pred_pht_index
  );
endinterface

// File: rtl/branch_target_predictor_sat_counter_table.sv
// Pattern history table: array of saturating counters with one combinational
// read port (MSB = predict taken) and one synchronous update port.
module branch_target_predictor_sat_counter_table
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES      = BTP_DEFAULT_ENTRIES,
  parameter int COUNTER_BITS = 2,
  parameter int IDX_BITS     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_index,
  output logic                rd_taken,
  input  logic [IDX_BITS-1:0] wr_index,
  input  pht_op_e             wr_op
);
  typedef logic [COUNTER_BITS-1:0] ctr_t;

  localparam ctr_t CTR_MAX     = '1;
  localparam ctr_t CTR_WEAK_T  = ctr_t'(1 << (COUNTER_BITS - 1));
  localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (COUNTER_BITS - 1)) - 1);

  ctr_t table_q [ENTRIES];
  ctr_t cur;
  ctr_t nxt;

  assign rd_taken = table_q[rd_index][COUNTER_BITS-1];

  // Next value of the addressed counter, saturating at both ends.
  always_comb begin
    // NOTE: default assignment first so every path drives nxt and no latch is inferred.
    cur = table_q[wr_index];
    nxt = cur;
    unique case (wr_op)
      PHT_INC:            if (cur != CTR_MAX) nxt = cur + ctr_t'(1);
      PHT_DEC:            if (cur != '0)      nxt = cur - ctr_t'(1);
      PHT_SET_WEAK_TAKEN: nxt = CTR_WEAK_T;
      default:            nxt = cur;
    endcase
  end

  // Counter storage; every entry returns to weakly-not-taken on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the whole array is reset because prediction depends on a defined counter value.
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_WEAK_NT;
    end else if (wr_op != PHT_HOLD) begin
      table_q[wr_index] <= nxt;
    end
  end
endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB plus PHT of saturating counters, zero-latency lookup for the
// fetch PC, trained by MEM-stage resolutions. PCs are 2-byte aligned.
// Optional: define BTP_GSHARE_EN to XOR a non-speculative global history
// register into the PHT index (BTB indexing is unaffected).
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES      = BTP_DEFAULT_ENTRIES,
  parameter int TAG_BITS     = 12,
  parameter int COUNTER_BITS = 2
) (
  input logic                      clk,
  input logic                      reset_n,
  branch_target_predictor_if.slave bus
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [BTP_MAX_TAG_BITS-1:0] tag_t;

  function automatic idx_t pc_index(logic [31:0] pc);
    return pc[IDX_BITS:1];
  endfunction

  function automatic tag_t pc_tag(logic [31:0] pc);
    return tag_t'(pc[IDX_BITS+TAG_BITS:IDX_BITS+1]);
  endfunction

  btb_entry_type  btb [ENTRIES];
  btp_update_type upd;

  assign upd = '{valid:           bus.upd_valid,
                 pc:              bus.upd_pc,
                 pht_index:       BTP_MAX_IDX_BITS'(bus.upd_pht_index),
                 is_branch:       bus.upd_is_branch,
                 is_jump:         bus.upd_is_jump,
                 taken:           bus.upd_taken,
                 correct_address: bus.upd_correct_address,
                 target:          bus.upd_target};

  // Lookup: reads registered state only, so a same-cycle update is not bypassed.
  idx_t          lk_idx;
  btb_entry_type lk_entry;
  logic          lk_hit;
  logic          lk_ctr_taken;

  assign lk_idx          = pc_index(bus.if_pc);
  assign lk_entry        = btb[lk_idx];
  assign lk_hit          = lk_entry.valid && (lk_entry.tag == pc_tag(bus.if_pc));
  assign bus.pred_taken  = lk_hit && (lk_entry.is_jump || lk_ctr_taken);
  assign bus.pred_target = lk_hit ? lk_entry.target : 32'h0;

  // Update side: flush suppresses the whole update.
  idx_t    u_idx;
  idx_t    u_pht_idx;
  logic    u_hit;
  logic    upd_act;
  logic    pht_en;
  logic    btb_write;
  pht_op_e pht_op;
  logic    unused_upd_bits;

  assign u_idx           = pc_index(upd.pc);
  assign u_pht_idx       = idx_t'(upd.pht_index);
  assign unused_upd_bits = ^upd.pht_index;
  assign u_hit           = btb[u_idx].valid && (btb[u_idx].tag == pc_tag(upd.pc));
  assign upd_act         = upd.valid && (upd.is_branch || upd.is_jump) && !bus.flush;
  assign pht_en          = upd_act && upd.is_branch;
  assign btb_write       = upd_act && upd.taken && (!u_hit || !upd.correct_address);

  // PHT action for this resolution; a fresh allocation restarts at weakly taken.
  always_comb begin
    pht_op = PHT_HOLD;
    if (pht_en) begin
      if (upd.taken && !u_hit) pht_op = PHT_SET_WEAK_TAKEN;
      else if (upd.taken)      pht_op = PHT_INC;
      else                     pht_op = PHT_DEC;
    end
  end

  branch_target_predictor_sat_counter_table #(
    .ENTRIES      (ENTRIES),
    .COUNTER_BITS (COUNTER_BITS),
    .IDX_BITS     (IDX_BITS)
  ) u_pht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (bus.pred_pht_index),
    .rd_taken (lk_ctr_taken),
    .wr_index (u_pht_idx),
    .wr_op    (pht_op)
  );

  // BTB storage: flush drops all valid bits; a write allocates or retargets one entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (btb_write) begin
      btb[u_idx] <= '{valid:   1'b1,
                      tag:     pc_tag(upd.pc),
                      target:  upd.target,
                      is_jump: upd.is_jump};
    end
  end

`ifdef BTP_GSHARE_EN
  idx_t ghr;

  // Global history of resolved conditional branches, newest outcome in bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ghr <= '0;
    else if (bus.flush) ghr <= '0;
    else if (pht_en)   ghr <= idx_t'({ghr, upd.taken});
  end

  assign bus.pred_pht_index = lk_idx ^ ghr;
`else
  assign bus.pred_pht_index = lk_idx;
`endif
endmodule
